// File: rtl/keccak_buffer_out.sv
// rtl/keccak_buffer_out.sv - ping-pong digest buffer draining LSB-first output words (option: KECCAK_OUT_BYTE_SWAP_EN)
module keccak_buffer_out #(
    parameter int OUT_BUF_INPUT = 256,
    parameter int OUT_BUF_SIZE  = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [OUT_BUF_INPUT-1:0] state_input,
    input  logic                     state_valid,
    output logic                     state_ready,
    output logic [OUT_BUF_SIZE-1:0]  buffer_output,
    output logic                     buffer_output_valid,
    input  logic                     output_ready,
    output logic                     last_word_output
);

    localparam int N  = OUT_BUF_INPUT / OUT_BUF_SIZE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(N - 1);

    logic [OUT_BUF_INPUT-1:0] r_slot0;
    logic [OUT_BUF_INPUT-1:0] r_slot1;
    logic                     r_wr_ptr;
    logic                     r_rd_ptr;
    logic [1:0]               r_count;
    logic [CW-1:0]            r_word_cnt;

    logic                     w_load;
    logic                     w_hs;
    logic                     w_last_hs;
    logic [OUT_BUF_INPUT-1:0] w_rd_slot;
    logic [OUT_BUF_SIZE-1:0]  w_word;
    logic [OUT_BUF_SIZE-1:0]  w_out;

    // Ready and valid come only from the registered occupancy count.
    assign state_ready         = (r_count < 2'd2);
    assign buffer_output_valid = (r_count != 2'd0);
    assign last_word_output    = buffer_output_valid && (r_word_cnt == LAST_WORD);

    assign w_load    = state_valid && state_ready;
    assign w_hs      = buffer_output_valid && output_ready;
    assign w_last_hs = w_hs && (r_word_cnt == LAST_WORD);

    assign w_rd_slot = r_rd_ptr ? r_slot1 : r_slot0;
    assign w_word    = w_rd_slot[r_word_cnt*OUT_BUF_SIZE +: OUT_BUF_SIZE];

    // Select output word, optionally reversing its byte order.
    always_comb begin
        w_out = w_word;
`ifdef KECCAK_OUT_BYTE_SWAP_EN
        for (int b = 0; b < OUT_BUF_SIZE / 8; b++) begin
            w_out[b*8 +: 8] = w_word[(OUT_BUF_SIZE/8 - 1 - b)*8 +: 8];
        end
`endif
    end

    assign buffer_output = w_out;

    // Slot loads, pointer/word-counter advance and occupancy tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot0    <= '0;
            r_slot1    <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_word_cnt <= '0;
        end else begin
            if (w_load) begin
                if (r_wr_ptr) begin
                    r_slot1 <= state_input;
                end else begin
                    r_slot0 <= state_input;
                end
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_hs) begin
                if (w_last_hs) begin
                    r_word_cnt <= '0;
                    r_rd_ptr   <= ~r_rd_ptr;
                end else begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                end
            end
            // A load and a digest retirement in the same cycle cancel out.
            case ({w_load, w_last_hs})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_buffer_out.sv
// tb/tb_keccak_buffer_out.sv - randomized and directed checks of keccak_buffer_out against a digest-queue model
module tb_keccak_buffer_out;

    localparam int IW = 256;
    localparam int OW = 64;
    localparam int N  = IW / OW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [IW-1:0] state_input = '0;
    logic          state_valid = 1'b0;
    logic          state_ready;
    logic [OW-1:0] buffer_output;
    logic          buffer_output_valid;
    logic          output_ready = 1'b0;
    logic          last_word_output;

    int tests = 0;
    int fails = 0;

    logic [IW-1:0] q[$];
    int            widx = 0;
    bit            live = 1'b0;

    keccak_buffer_out #(.OUT_BUF_INPUT(IW), .OUT_BUF_SIZE(OW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .state_input         (state_input),
        .state_valid         (state_valid),
        .state_ready         (state_ready),
        .buffer_output       (buffer_output),
        .buffer_output_valid (buffer_output_valid),
        .output_ready        (output_ready),
        .last_word_output    (last_word_output)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] sw(input logic [OW-1:0] x);
        logic [OW-1:0] y;
        y = x;
`ifdef KECCAK_OUT_BYTE_SWAP_EN
        for (int b = 0; b < OW / 8; b++) y[b*8 +: 8] = x[(OW/8 - 1 - b)*8 +: 8];
`endif
        return y;
    endfunction

    function automatic logic [IW-1:0] mk(input logic [OW-1:0] base);
        logic [IW-1:0] d;
        for (int k = 0; k < N; k++) d[k*OW +: OW] = base + OW'(k);
        return d;
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO of whole digests plus index of the word currently offered.
    task automatic model_step();
        bit hs;
        bit ld;
        if (reset) begin
            q.delete();
            widx = 0;
            live = 1'b1;
        end else if (live) begin
            hs = (q.size() > 0) && output_ready;
            ld = state_valid && (q.size() < 2);
            if (hs) begin
                if (widx == N - 1) begin
                    void'(q.pop_front());
                    widx = 0;
                end else begin
                    widx++;
                end
            end
            if (ld) q.push_back(state_input);
        end
    endtask

    // Advance the model on every rising edge using the inputs the DUT sees.
    always @(posedge clk) model_step();

    // Compare DUT outputs with the model between edges.
    always @(negedge clk) begin
        if (live) begin
            check("state_ready", OW'(state_ready), OW'(q.size() < 2));
            check("valid", OW'(buffer_output_valid), OW'(q.size() > 0));
            check("last", OW'(last_word_output), OW'((q.size() > 0) && (widx == N - 1)));
            if (q.size() > 0) check("data", buffer_output, sw(q[0][widx*OW +: OW]));
        end
    end

    task automatic drive(input logic v, input logic [IW-1:0] d, input logic r, input logic rs);
        state_valid  = v;
        state_input  = d;
        output_ready = r;
        reset        = rs;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [IW-1:0] da, db, dc, dsw;
        logic [IW-1:0] dd[3];
        int            di;
        int            nvalid;
        bit            pre_rdy;

        da = mk(64'hA0);
        db = mk(64'hB0);
        dc = mk(64'hC0);
        dd[0] = mk(64'h100); dd[1] = mk(64'h200); dd[2] = mk(64'h300);

        @(negedge clk);
        drive(0, '0, 0, 1);
        check("rst_ready", OW'(state_ready), 64'd1);
        check("rst_valid", OW'(buffer_output_valid), 64'd0);
        check("rst_last", OW'(last_word_output), 64'd0);
        check("rst_data", buffer_output, 64'd0);

        // Straight drain of A0..A3.
        drive(1, da, 1, 0);
        check("a_w0", buffer_output, sw(64'hA0));
        drive(0, '0, 1, 0);
        check("a_w1", buffer_output, sw(64'hA1));
        check("a_w1_last", OW'(last_word_output), 64'd0);
        drive(0, '0, 1, 0);
        drive(0, '0, 1, 0);
        check("a_w3", buffer_output, sw(64'hA3));
        check("a_w3_last", OW'(last_word_output), 64'd1);
        drive(0, '0, 1, 0);
        check("a_done_valid", OW'(buffer_output_valid), 64'd0);

        // Stall three cycles on A1.
        drive(1, da, 0, 0);
        drive(0, '0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 0, 0);
            check("stall_w1", buffer_output, sw(64'hA1));
            check("stall_valid", OW'(buffer_output_valid), 64'd1);
        end
        drive(0, '0, 1, 0);
        check("stall_w2", buffer_output, sw(64'hA2));
        drive(0, '0, 1, 0);
        check("stall_w3", buffer_output, sw(64'hA3));
        drive(0, '0, 1, 0);

        // Three digests offered back to back.
        di = 0;
        nvalid = 0;
        for (int c = 0; c < 16; c++) begin
            pre_rdy = state_ready;
            drive(di < 3, (di < 3) ? dd[di] : '0, 1, 0);
            if (pre_rdy && di < 3) di++;
            if (c == 1) check("b2b_full_ready", OW'(state_ready), 64'd0);
            if (buffer_output_valid) nvalid++;
        end
        check("b2b_all_loaded", OW'(di), 64'd3);
        check("b2b_words", OW'(nvalid), 64'd12);

        // Load coinciding with last-word handshake.
        drive(1, db, 1, 0);
        drive(0, '0, 1, 0);
        drive(0, '0, 1, 0);
        drive(0, '0, 1, 0);
        check("ov_w3", buffer_output, sw(64'hB3));
        drive(1, dc, 1, 0);
        check("ov_next_w0", buffer_output, sw(64'hC0));
        check("ov_ready", OW'(state_ready), 64'd1);
        for (int i = 0; i < 4; i++) drive(0, '0, 1, 0);

        // Reset mid-drain.
        drive(1, da, 1, 0);
        drive(0, '0, 1, 0);
        drive(0, '0, 1, 1);
        check("mr_valid", OW'(buffer_output_valid), 64'd0);
        check("mr_last", OW'(last_word_output), 64'd0);
        check("mr_ready", OW'(state_ready), 64'd1);
        check("mr_data", buffer_output, 64'd0);
        drive(0, '0, 1, 0);
        check("mr_stays_empty", OW'(buffer_output_valid), 64'd0);

        // Byte order of an output word.
        dsw = '0;
        dsw[63:0] = 64'h0102030405060708;
        drive(1, dsw, 0, 0);
`ifdef KECCAK_OUT_BYTE_SWAP_EN
        check("swap_w0", buffer_output, 64'h0807060504030201);
`else
        check("swap_w0", buffer_output, 64'h0102030405060708);
`endif
        drive(0, '0, 0, 1);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [IW-1:0] rd;
            for (int k = 0; k < IW / 32; k++) rd[k*32 +: 32] = $urandom;
            drive($urandom_range(0, 1) == 1, rd, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 199) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keccak_buffer_out.md
KECCAK_BUFFER_OUT -- requirements
Module: keccak_buffer_out

Interface
REQ-001 SHALL have parameter OUT_BUF_INPUT, default 256, width of a digest loaded per transfer (bits).
REQ-002 SHALL have parameter OUT_BUF_SIZE, default 64, width of one output word (bits); OUT_BUF_INPUT/OUT_BUF_SIZE = N, integer, N >= 2.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port state_input  input  OUT_BUF_INPUT  digest from permutation core.
REQ-006 SHALL have port state_valid  input  1  state_input valid.
REQ-007 SHALL have port state_ready  output  1  a digest slot is free.
REQ-008 SHALL have port buffer_output  output  OUT_BUF_SIZE  current output word.
REQ-009 SHALL have port buffer_output_valid  output  1  buffer_output valid.
REQ-010 SHALL have port output_ready  input  1  downstream accepts word.
REQ-011 SHALL have port last_word_output  output  1  current word is word N-1 of its digest.

Function
REQ-012 SHALL hold two digest slots (ping-pong), a write pointer, a read pointer, occupancy count 0..2 and a word counter 0..N-1, all registered.
REQ-013 SHALL load state_input into the slot at write pointer, toggle write pointer and increment count on a cycle with state_valid && state_ready.
REQ-014 SHALL drive state_ready = (count < 2), from registered count only; no combinational path from output_ready.
REQ-015 SHALL drive buffer_output_valid = (count > 0); first word valid the cycle after the loading edge (latency 1).
REQ-016 SHALL present word k of the read slot as bits [k*OUT_BUF_SIZE +: OUT_BUF_SIZE], k = word counter; word 0 first (LSB-first).
REQ-017 SHALL advance the word counter on buffer_output_valid && output_ready; buffer_output and last_word_output stable while valid && !output_ready.
REQ-018 SHALL assert last_word_output = buffer_output_valid && (word counter == N-1).
REQ-019 SHALL, on handshake of word N-1, wrap word counter to 0, toggle read pointer, decrement count.
REQ-020 SHALL keep count unchanged when a load and a last-word handshake occur in the same cycle (count 1); the loaded digest begins output the next cycle with no bubble.
REQ-021 SHALL ignore state_valid when count == 2 (no overwrite); state_ready rises the cycle after the last-word handshake.
REQ-022 SHALL produce output words back to back, one per cycle, with output_ready held high, including across digest boundaries.
REQ-023 SHALL ignore output_ready when buffer_output_valid is 0.

Reset
REQ-024 SHALL, on reset high at a clock edge, clear count, pointers, word counter and both slots to 0, discarding any digest mid-drain.
REQ-025 SHALL drive after reset: state_ready 1, buffer_output_valid 0, last_word_output 0, buffer_output 0.
REQ-026 SHALL give reset priority over simultaneous load or handshake.

Configuration
REQ-027 SHALL, with macro KECCAK_OUT_BYTE_SWAP_EN defined, reverse byte order within each output word (byte 0 to byte OUT_BUF_SIZE/8-1); requires OUT_BUF_SIZE multiple of 8.
REQ-028 SHALL, without KECCAK_OUT_BYTE_SWAP_EN, output words unmodified; word order, timing and handshake identical in both builds.

Verification (OUT_BUF_INPUT=256, OUT_BUF_SIZE=64, N=4)
REQ-029 SHALL cover: load digest with words 64'hA0,64'hA1,64'hA2,64'hA3, output_ready=1 -> A0..A3 on 4 consecutive cycles starting 1 cycle after load, last_word_output only with A3, then valid 0.
REQ-030 SHALL cover: same digest, output_ready low 3 cycles at word A1 -> A1 and valid held stable 3 cycles, then A2,A3 follow.
REQ-031 SHALL cover: three digests D0,D1,D2 offered back to back, output_ready=1 -> D0,D1 accepted, state_ready 0 until cycle after D0 word 3 handshake, 12 words out without gaps, D2 order preserved.
REQ-032 SHALL cover: count 1, load D1 in same cycle as D0 word 3 handshake -> D1 word 0 next cycle, state_ready stays 1.
REQ-033 SHALL cover: reset asserted after D0 word 1 accepted -> next cycle valid 0, last 0, state_ready 1, buffer_output 0; D0 words 2,3 never appear.
REQ-034 SHALL cover: KECCAK_OUT_BYTE_SWAP_EN defined, word 0 = 64'h0102030405060708 -> buffer_output 64'h0807060504030201; undefined -> 64'h0102030405060708.
